riscv_decoder: RTL and testbench

- Registered RV32I instruction-field decoder in the core's decode stage, between fetch and register-file read/execute.
- Takes a raw 32-bit instruction and, one clock later, presents:
  - register specifiers,
  - sign-extended immediate,
  - function fields,
  - format class,
  - illegal-instruction flag.

---
 rtl/riscv_decoder.sv | 193 +++++++++++++++++++
 tb/tb_riscv_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decoder.sv
// RV32I decode-stage field decoder.
// One register stage: fields, immediate, format class and illegal flag.
module riscv_decoder #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction_i,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [2:0]        instr_type_o,
    output logic              illegal_o
);

    localparam logic [2:0] T_R    = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_NONE = 3'd7;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;

    logic [REG_AW-1:0] rs1_d, rs1_q;
    logic [REG_AW-1:0] rs2_d, rs2_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic [XLEN-1:0]   imm_d, imm_q;
    logic [6:0]        opcode_d, opcode_q;
    logic [2:0]        funct3_d, funct3_q;
    logic [6:0]        funct7_d, funct7_q;
    logic [2:0]        type_d, type_q;
    logic              illegal_d, illegal_q;

    // Classify the opcode into a format and screen out reserved encodings.
    always_comb begin
        op     = instruction_i[6:0];
        f3     = instruction_i[14:12];
        f7     = instruction_i[31:25];
        bad    = 1'b0;
        type_d = T_NONE;
        case (op)
            OP_OP: begin
                type_d = T_R;
                bad = !((f7 == 7'h00) ||
                        (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_OPIMM: begin
                type_d = T_I;
                if (f3 == 3'b001)
                    bad = (f7 != 7'h00);
                else if (f3 == 3'b101)
                    bad = !(f7 == 7'h00 || f7 == 7'h20);
            end
            OP_LOAD: begin
                type_d = T_I;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_JALR: begin
                type_d = T_I;
                bad = (f3 != 3'b000);
            end
            OP_SYSTEM, OP_FENCE: type_d = T_I;
            OP_STORE: begin
                type_d = T_S;
                bad = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                type_d = T_B;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI, OP_AUIPC: type_d = T_U;
            OP_JAL:           type_d = T_J;
            default:          bad = 1'b1;
        endcase
        if (instruction_i[1:0] != 2'b11)
            bad = 1'b1;
        if (bad)
            type_d = T_NONE;
    end

    // Extract the fields the selected format actually carries.
    always_comb begin
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        imm_d     = '0;
        funct3_d  = '0;
        funct7_d  = '0;
        opcode_d  = op;
        illegal_d = bad;
        case (type_d)
            T_R: begin
                rd_d     = instruction_i[11:7];
                rs1_d    = instruction_i[19:15];
                rs2_d    = instruction_i[24:20];
                funct3_d = f3;
                funct7_d = f7;
            end
            T_I: begin
                rd_d     = instruction_i[11:7];
                rs1_d    = instruction_i[19:15];
                funct3_d = f3;
                imm_d    = {{(XLEN-11){instruction_i[31]}},
                            instruction_i[30:20]};
            end
            T_S: begin
                rs1_d    = instruction_i[19:15];
                rs2_d    = instruction_i[24:20];
                funct3_d = f3;
                imm_d    = {{(XLEN-11){instruction_i[31]}},
                            instruction_i[30:25], instruction_i[11:7]};
            end
            T_B: begin
                rs1_d    = instruction_i[19:15];
                rs2_d    = instruction_i[24:20];
                funct3_d = f3;
                imm_d    = {{(XLEN-12){instruction_i[31]}},
                            instruction_i[7], instruction_i[30:25],
                            instruction_i[11:8], 1'b0};
            end
            T_U: begin
                rd_d  = instruction_i[11:7];
                imm_d = {{(XLEN-31){instruction_i[31]}},
                         instruction_i[30:12], 12'b0};
            end
            T_J: begin
                rd_d  = instruction_i[11:7];
                imm_d = {{(XLEN-20){instruction_i[31]}},
                         instruction_i[19:12], instruction_i[20],
                         instruction_i[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Output register stage; reset wins over the word being decoded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            type_q    <= T_NONE;
            illegal_q <= 1'b0;
        end else begin
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            type_q    <= type_d;
            illegal_q <= illegal_d;
        end
    end

    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign rd_o         = rd_q;
    assign imm_o        = imm_q;
    assign opcode_o     = opcode_q;
    assign funct3_o     = funct3_q;
    assign funct7_o     = funct7_q;
    assign instr_type_o = type_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_riscv_decoder.sv
// Self-checking bench for riscv_decoder.
// Directed table, reset sequences and random words against a model.
module tb_riscv_decoder;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction_i = 32'h0;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [2:0]  funct3_o, instr_type_o;
    logic        illegal_o;

    int n_vec = 0;
    int n_miss = 0;

    riscv_decoder #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .instruction_i(instruction_i),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .instr_type_o(instr_type_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // Expected decode from the instruction-set rules, written as lookups.
    function automatic exp_t model(logic [31:0] w);
        exp_t e;
        int   fmt;
        bit   ok;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.op = op;
        fmt = 7;
        ok = 1;
        if (op == 7'h33) begin
            fmt = 0;
            ok = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
        end else if (op == 7'h13) begin
            fmt = 1;
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) ok = f7 inside {7'h00, 7'h20};
        end else if (op == 7'h03) begin
            fmt = 1;
            ok = !(f3 inside {3'd3, 3'd6, 3'd7});
        end else if (op == 7'h67) begin
            fmt = 1;
            ok = (f3 == 0);
        end else if (op inside {7'h73, 7'h0F}) begin
            fmt = 1;
        end else if (op == 7'h23) begin
            fmt = 2;
            ok = (f3 <= 2);
        end else if (op == 7'h63) begin
            fmt = 3;
            ok = !(f3 inside {3'd2, 3'd3});
        end else if (op inside {7'h37, 7'h17}) begin
            fmt = 4;
        end else if (op == 7'h6F) begin
            fmt = 5;
        end else begin
            ok = 0;
        end
        if (w[1:0] != 2'b11) ok = 0;
        if (!ok) begin
            e.typ = 3'd7;
            e.ill = 1'b1;
            return e;
        end
        e.typ = 3'(fmt);
        if (fmt inside {0, 1, 4, 5}) e.rd = w[11:7];
        if (fmt inside {0, 1, 2, 3}) e.rs1 = w[19:15];
        if (fmt inside {0, 2, 3}) e.rs2 = w[24:20];
        if (fmt inside {0, 1, 2, 3}) e.f3 = f3;
        if (fmt == 0) e.f7 = f7;
        if (fmt == 1) e.imm = 32'($signed(w) >>> 20);
        if (fmt == 2) e.imm = 32'(($signed({w[31:25], w[11:7], 20'b0})) >>> 20);
        if (fmt == 3)
            e.imm = 32'(($signed({w[31], w[7], w[30:25], w[11:8], 20'b0})) >>> 19);
        if (fmt == 4) e.imm = w & 32'hFFFF_F000;
        if (fmt == 5)
            e.imm = 32'(($signed({w[31], w[19:12], w[20], w[30:21], 12'b0})) >>> 11);
        return e;
    endfunction

    function automatic exp_t mk(logic [31:0] w, int rd, int rs1, int rs2,
                                logic [31:0] imm, int f3, int f7, int typ,
                                bit ill);
        exp_t e;
        e.rd  = 5'(rd);
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.imm = imm;
        e.op  = w[6:0];
        e.f3  = 3'(f3);
        e.f7  = 7'(f7);
        e.typ = 3'(typ);
        e.ill = ill;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.typ = 3'd7;
        return e;
    endfunction

    task automatic check(string name, exp_t e);
        exp_t a;
        a.rs1 = rs1_o;  a.rs2 = rs2_o;  a.rd = rd_o;  a.imm = imm_o;
        a.op = opcode_o; a.f3 = funct3_o; a.f7 = funct7_o;
        a.typ = instr_type_o; a.ill = illegal_o;
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got rd=%0d rs1=%0d rs2=%0d imm=%h op=%b f3=%0d f7=%h typ=%0d ill=%b exp rd=%0d rs1=%0d rs2=%0d imm=%h op=%b f3=%0d f7=%h typ=%0d ill=%b",
                     name, a.rd, a.rs1, a.rs2, a.imm, a.op, a.f3, a.f7,
                     a.typ, a.ill, e.rd, e.rs1, e.rs2, e.imm, e.op, e.f3,
                     e.f7, e.typ, e.ill);
        end
    endtask

    task automatic step(logic r, logic [31:0] w);
        @(negedge clk);
        rst = r;
        instruction_i = w;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [$];
    logic [6:0] ops [0:10];

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

        tbl.push_back('{"addi",  32'h00C00093, mk(32'h00C00093, 1,0,0, 32'd12, 0,0,1,0)});
        tbl.push_back('{"nop",   32'h00000013, mk(32'h00000013, 0,0,0, 32'd0, 0,0,1,0)});
        tbl.push_back('{"lhu",   32'h00C15083, mk(32'h00C15083, 1,2,0, 32'd12, 5,0,1,0)});
        tbl.push_back('{"ld3",   32'h00C13083, mk(32'h00C13083, 0,0,0, 32'd0, 0,0,7,1)});
        tbl.push_back('{"sw",    32'h0020A423, mk(32'h0020A423, 0,1,2, 32'd8, 2,0,2,0)});
        tbl.push_back('{"beq",   32'hFE000EE3, mk(32'hFE000EE3, 0,0,0, 32'hFFFFFFFC, 0,0,3,0)});
        tbl.push_back('{"add",   32'h002081B3, mk(32'h002081B3, 3,1,2, 32'd0, 0,0,0,0)});
        tbl.push_back('{"sub",   32'h402081B3, mk(32'h402081B3, 3,1,2, 32'd0, 0,32,0,0)});
        tbl.push_back('{"f7bad", 32'h402091B3, mk(32'h402091B3, 0,0,0, 32'd0, 0,0,7,1)});
        tbl.push_back('{"lui",   32'h123452B7, mk(32'h123452B7, 5,0,0, 32'h12345000, 0,0,4,0)});
        tbl.push_back('{"jal",   32'h001000EF, mk(32'h001000EF, 1,0,0, 32'd2048, 0,0,5,0)});
        tbl.push_back('{"zero",  32'h00000000, mk(32'h00000000, 0,0,0, 32'd0, 0,0,7,1)});
        tbl.push_back('{"slli",  32'h00309093, mk(32'h00309093, 1,1,0, 32'd3, 1,0,1,0)});
        tbl.push_back('{"srai",  32'h4030D093, mk(32'h4030D093, 1,1,0, 32'h403, 5,0,1,0)});
        tbl.push_back('{"sraibd",32'h8030D093, mk(32'h8030D093, 0,0,0, 32'd0, 0,0,7,1)});
        tbl.push_back('{"lo01",  32'h00C00091, mk(32'h00C00091, 0,0,0, 32'd0, 0,0,7,1)});
        tbl.push_back('{"jalrbd",32'h000090E7, mk(32'h000090E7, 0,0,0, 32'd0, 0,0,7,1)});
        tbl.push_back('{"sbad",  32'h0020B423, mk(32'h0020B423, 0,0,0, 32'd0, 0,0,7,1)});

        // Reset held for two edges with a valid word present.
        step(1'b0, 32'h00C00093);
        check("rst_cyc1", reset_exp());
        step(1'b0, 32'h00C00093);
        check("rst_cyc2", reset_exp());
        step(1'b1, 32'h00C00093);
        check("rst_release", mk(32'h00C00093, 1,0,0, 32'd12, 0,0,1,0));

        // Directed table, applied back to back.
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].instr);
            check(tbl[i].name, tbl[i].e);
        end

        // lui then jal on consecutive edges; no leftover fields.
        step(1'b1, 32'h123452B7);
        check("b2b_lui", mk(32'h123452B7, 5,0,0, 32'h12345000, 0,0,4,0));
        step(1'b1, 32'h001000EF);
        check("b2b_jal", mk(32'h001000EF, 1,0,0, 32'd2048, 0,0,5,0));

        // Reset arriving mid-stream clears a decoded illegal word.
        step(1'b1, 32'h00000000);
        check("pre_rst_ill", mk(32'h0, 0,0,0, 32'd0, 0,0,7,1));
        step(1'b0, 32'h002081B3);
        check("rst_midstream", reset_exp());
        step(1'b1, 32'h402081B3);
        check("post_rst_sub", mk(32'h402081B3, 3,1,2, 32'd0, 0,32,0,0));

        // Random words, biased toward legal opcodes and funct7 values.
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 9) < 8)
                w[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 2) == 0)
                w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            step(1'b1, w);
            check($sformatf("rnd%0d_%h", k, w), model(w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
